mem_arbiter: RTL and testbench

- Arbitrates between the instruction-fetch requester (I) and the load/store requester (D) for one shared memory port (M).
- Allows one outstanding transaction at a time.
- Sits between the multi-cycle core front end / LSU and the unified memory model; replaces the separate inst/data memory instances.
- Adds request registering, response routing and a response watchdog.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D), one transaction in
// flight, with a response watchdog. Define ARB_ROUND_ROBIN_EN for alternating grants on contention.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [7:0]        d_wmask,
    input  logic              d_wen,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [7:0]        m_wmask,
    output logic              m_wen,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              resp_err,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    // Counter is cleared on entry to RESP, so the last waiting cycle sees TIMEOUT-1.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = D, 0 = I
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic              wen_q, wen_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              win_i, win_d;
    logic              timeout_hit, resp_fire;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;  // 1 = D

    always_comb begin
        win_i = 1'b0;
        win_d = 1'b0;
        if (state_q == StIdle) begin
            if (i_req_valid && d_req_valid) begin
                win_d = ~last_grant_q;
                win_i = last_grant_q;
            end else begin
                win_d = d_req_valid;
                win_i = i_req_valid;
            end
        end
        last_grant_d = last_grant_q;
        if (win_d) begin
            last_grant_d = 1'b1;
        end else if (win_i) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        win_d = (state_q == StIdle) && d_req_valid;
        win_i = (state_q == StIdle) && i_req_valid && !d_req_valid;
    end
`endif

    always_comb begin
        timeout_hit = (state_q == StResp) && !m_resp_valid && (cnt_q == TimeoutLast);
        resp_fire   = (state_q == StResp) && (m_resp_valid || timeout_hit);

        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (win_d) begin
                    owner_d = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wmask_d = d_wmask;
                    wen_d   = d_wen;
                    state_d = StReq;
                end else if (win_i) begin
                    owner_d = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                    wen_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (m_req_ready) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                cnt_d = cnt_q + 8'd1;
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        i_req_ready  = win_i;
        d_req_ready  = win_d;
        m_req_valid  = (state_q == StReq);
        m_addr       = addr_q;
        m_wdata      = wdata_q;
        m_wmask      = wmask_q;
        m_wen        = wen_q;
        i_resp_valid = resp_fire && !owner_q;
        d_resp_valid = resp_fire && owner_q;
        // Timeout completions return zero data.
        i_rdata      = (i_resp_valid && m_resp_valid) ? m_rdata : '0;
        d_rdata      = (d_resp_valid && m_resp_valid) ? m_rdata : '0;
        resp_err     = resp_fire && !m_resp_valid;
        busy         = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reactive memory model, request and response queues.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req_valid, d_req_ready, d_wen, d_resp_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  d_wmask, m_wmask;
    logic        m_req_valid, m_req_ready, m_wen, m_resp_valid, resp_err, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wen(d_wen),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen),
        .m_resp_valid(m_resp_valid), .m_rdata(m_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic        wen;
    } mreq_t;
    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    mreq_t req_q[$];
    resp_t resp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model: ready after ready_delay REQ cycles, response resp_delay cycles into RESP.
    int    ready_delay = 0, resp_delay = 0;
    bit    no_resp = 1'b0, late_resp = 1'b0;
    int    phase = 0, rcnt = 0, hs_cyc = 0;
    mreq_t cap, exp_req;

    initial begin
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_rdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            m_req_ready  = 1'b0;
            m_resp_valid = 1'b0;
            m_rdata      = '0;
            if (!rst) begin
                phase = 0;
            end else begin
                if (phase == 2) begin
                    if (no_resp) begin
                        if (!busy) phase = 0;
                    end else if (rcnt == resp_delay) begin
                        m_resp_valid = 1'b1;
                        m_rdata      = mem_rd(cap.addr);
                        phase        = 0;
                    end else begin
                        rcnt++;
                    end
                end
                if (phase == 0) begin
                    if (late_resp) begin
                        m_resp_valid = 1'b1;
                        m_rdata      = 32'hBAD0_BAD0;
                        late_resp    = 1'b0;
                    end
                    if (m_req_valid) begin
                        cap = '{is_d: 1'b0, addr: m_addr, wdata: m_wdata, wmask: m_wmask,
                                wen: m_wen};
                        if (req_q.size() == 0) begin
                            check_eq("m_req_unexpected", 64'd1, 64'd0);
                        end else begin
                            exp_req = req_q.pop_front();
                            check_eq("m_addr", m_addr, exp_req.addr);
                            check_eq("m_wen", m_wen, exp_req.wen);
                            check_eq("m_wmask", m_wmask, exp_req.wmask);
                            if (exp_req.is_d) check_eq("m_wdata", m_wdata, exp_req.wdata);
                        end
                        rcnt  = 0;
                        phase = 1;
                    end
                end
                if (phase == 1) begin
                    if (rcnt > 0) begin
                        check_eq("m_req_valid_held", m_req_valid, 1'b1);
                        check_eq("m_stable", {m_addr, m_wdata},
                                 {cap.addr, cap.wdata});
                        check_eq("m_ctl_stable", {m_wmask, m_wen}, {cap.wmask, cap.wen});
                    end
                    if (rcnt == ready_delay) begin
                        m_req_ready = 1'b1;
                        hs_cyc      = cyc;
                        phase       = 2;
                        rcnt        = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end
        end
    end

    // Response monitor.
    int    resp_cyc = 0, resp_count = 0;
    resp_t exp_resp;

    always @(negedge clk) begin
        if (i_resp_valid || d_resp_valid) begin
            resp_cyc = cyc;
            resp_count++;
            check_eq("resp_onehot", i_resp_valid & d_resp_valid, 1'b0);
            check_eq("no_accept_on_resp", {i_req_ready, d_req_ready}, 2'b00);
            if (resp_q.size() == 0) begin
                check_eq("resp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_resp = resp_q.pop_front();
                check_eq("resp_owner_d", d_resp_valid, exp_resp.is_d);
                check_eq("resp_rdata", d_resp_valid ? d_rdata : i_rdata, exp_resp.rdata);
                check_eq("resp_err", resp_err, exp_resp.err);
            end
        end else begin
            check_eq("resp_err_idle", resp_err, 1'b0);
        end
        if (!i_resp_valid) check_eq("i_rdata_zero", i_rdata, 32'd0);
        if (!d_resp_valid) check_eq("d_rdata_zero", d_rdata, 32'd0);
    end

    task automatic req_one(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [7:0] wmask, input bit wen, output int acc);
        req_q.push_back('{is_d: is_d, addr: addr, wdata: is_d ? wdata : 32'd0,
                          wmask: is_d ? wmask : 8'd0, wen: is_d ? wen : 1'b0});
        resp_q.push_back('{is_d: is_d, rdata: no_resp ? 32'd0 : mem_rd(addr), err: no_resp});
        if (is_d) begin
            d_req_valid = 1'b1; d_addr = addr; d_wdata = wdata; d_wmask = wmask; d_wen = wen;
        end else begin
            i_req_valid = 1'b1; i_addr = addr;
        end
        acc = -1;
        for (int k = 0; k < 50 && acc < 0; k++) begin
            @(negedge clk);
            if (is_d ? d_req_ready : i_req_ready) acc = cyc;
        end
        if (acc < 0) check_eq("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (resp_q.size() == 0 && req_q.size() == 0 && !busy && phase == 0) ok = 1'b1;
        end
        check_eq("drain", ok, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_q.delete();
        resp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] ia(input int k);
        return 32'h8000_0100 + 32'(4 * k);
    endfunction
    function automatic logic [31:0] da(input int k);
        return 32'h8000_2000 + 32'(4 * k);
    endfunction

    int acc, ni, nd, total, cnt_before;
    bit gi, gd;

    initial begin
        i_req_valid = 1'b0; i_addr = '0;
        d_req_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0; d_wen = 1'b0;

        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_m_ctl", {m_req_valid, m_wen, m_wmask}, 10'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_m_wdata", m_wdata, 32'd0);
        check_eq("rst_resp", {i_resp_valid, d_resp_valid, resp_err}, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", {i_req_ready, d_req_ready}, 2'b00);
        @(posedge clk);
        #1;

        // Single fetch, minimum latency.
        req_one(1'b0, 32'h8000_0000, 32'h0, 8'h0, 1'b0, acc);
        wait_idle();
        check_eq("fetch_latency", resp_cyc - acc, 2);

        // Store with 3 cycles of backpressure.
        ready_delay = 3;
        @(posedge clk);
        #1;
        req_one(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 1'b1, acc);
        wait_idle();
        check_eq("store_latency", resp_cyc - acc, 5);
        ready_delay = 0;

        // Contention from reset.
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 2; k++) begin
            req_q.push_back('{is_d: 1'b0, addr: ia(k), wdata: 32'd0, wmask: 8'd0, wen: 1'b0});
            resp_q.push_back('{is_d: 1'b0, rdata: mem_rd(ia(k)), err: 1'b0});
            req_q.push_back('{is_d: 1'b1, addr: da(k), wdata: 32'd0, wmask: 8'd0, wen: 1'b0});
            resp_q.push_back('{is_d: 1'b1, rdata: mem_rd(da(k)), err: 1'b0});
        end
`else
        for (int k = 0; k < 4; k++) begin
            req_q.push_back('{is_d: 1'b1, addr: da(k), wdata: 32'd0, wmask: 8'd0, wen: 1'b0});
            resp_q.push_back('{is_d: 1'b1, rdata: mem_rd(da(k)), err: 1'b0});
        end
`endif
        ni = 0; nd = 0; total = 0;
        i_req_valid = 1'b1; i_addr = ia(0);
        d_req_valid = 1'b1; d_addr = da(0); d_wen = 1'b0; d_wmask = '0; d_wdata = '0;
        for (int k = 0; k < 200 && total < 4; k++) begin
            @(negedge clk);
            gi = i_req_ready;
            gd = d_req_ready;
            check_eq("one_ready", gi & gd, 1'b0);
            @(posedge clk);
            #1;
            if (gi) begin ni++; total++; i_addr = ia(ni); end
            if (gd) begin nd++; total++; d_addr = da(nd); end
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        check_eq("grants_i", ni, 2);
        check_eq("grants_d", nd, 2);
`else
        check_eq("grants_i", ni, 0);
        check_eq("grants_d", nd, 4);
`endif
        wait_idle();

        // Watchdog completion, then a late response that must be dropped.
        no_resp = 1'b1;
        @(posedge clk);
        #1;
        req_one(1'b0, 32'h8000_0040, 32'h0, 8'h0, 1'b0, acc);
        wait_idle();
        check_eq("timeout_cycles", resp_cyc - hs_cyc, TO);
        check_eq("timeout_busy_clear", cyc - resp_cyc, 1);
        cnt_before = resp_count;
        late_resp  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("late_resp_dropped", resp_count, cnt_before);
        check_eq("late_busy", busy, 1'b0);

        // Asynchronous reset while waiting in RESP.
        @(posedge clk);
        #1;
        req_one(1'b1, 32'h8000_2200, 32'h1234_5678, 8'hFF, 1'b1, acc);
        for (int k = 0; k < 20 && phase != 2; k++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #3;
        check_eq("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_m_req_valid", m_req_valid, 1'b0);
        check_eq("arst_resp", {i_resp_valid, d_resp_valid, resp_err}, 3'd0);
        req_q.delete();
        resp_q.delete();
        cnt_before = resp_count;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        no_resp = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("arst_no_resp", resp_count, cnt_before);
        @(posedge clk);
        #1;
        req_one(1'b1, 32'h8000_3000, 32'h0, 8'h0, 1'b0, acc);
        wait_idle();
        check_eq("post_rst_latency", resp_cyc - acc, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
